// File: rtl/alu_pkg.sv
// Shared constants for the alu and its round-robin front end:
// opcodes, FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    // The spare encoding 2'b11 behaves exactly like IDLE.
    function automatic logic [1:0] st_decode(input logic [1:0] s);
        return (s == ST_EXEC || s == ST_RESP) ? s : ST_IDLE;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational alu: add, subtract (CF = borrow), and, xor.
// CF is the bit just above the result; the logic ops always clear it.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             cf
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        case (op)
            OP_ADD:  sum = {1'b0, a} + {1'b0, b};
            OP_SUB:  sum = {1'b0, a} - {1'b0, b};
            OP_AND:  sum = {1'b0, a & b};
            OP_XOR:  sum = {1'b0, a ^ b};
            default: sum = '0;
        endcase
    end

    assign r  = sum[WIDTH-1:0];
    assign cf = sum[WIDTH];

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  winner,
    output logic            found
);

    always_comb begin
        int          idx;
        logic [NREQ-1:0] sh;
        winner = '0;
        found  = 1'b0;
        // Walk from the farthest offset back to ptr so the closest hit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sh = valid >> idx;
            if (sh[0]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between NREQ requesters.
// One op in flight at a time: IDLE (grant) -> EXEC (compute) -> RESP (hand off).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = 1,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_r,
    output logic                  rsp_cf,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_cnt
);

    logic [1:0]       state;
    logic [1:0]       cur;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   winner;
    logic             found;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_op;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] alu_r;
    logic             alu_cf;

    rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .winner(winner),
        .found (found)
    );

    // The alu only ever sees the registered operands, never the live request.
    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a (op_a),
        .b (op_b),
        .op(op_op),
        .r (alu_r),
        .cf(alu_cf)
    );

    assign cur  = st_decode(state);
    assign busy = (cur != ST_IDLE);

    always_comb begin
        req_ready = '0;
        if (rst_n && cur == ST_IDLE && found) req_ready = NREQ'(1) << winner;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_op     <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
            rsp_cf    <= 1'b0;
            rsp_id    <= '0;
            done_cnt  <= '0;
        end else begin
            case (cur)
                ST_IDLE: begin
                    state <= ST_IDLE;
                    if (found) begin
                        op_a   <= WIDTH'(req_a >> (int'(winner) * WIDTH));
                        op_b   <= WIDTH'(req_b >> (int'(winner) * WIDTH));
                        op_op  <= 2'(req_op >> (int'(winner) * 2));
                        op_id  <= winner;
                        rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_r     <= alu_r;
                    rsp_cf    <= alu_cf;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of grants, results and counts.
module tb_alu_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 4;
    localparam int IDW   = 1;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*2-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_r;
    logic                  rsp_cf;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
    logic [CNT_W-1:0]      done_cnt;

    alu_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_cf(rsp_cf), .rsp_id(rsp_id),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             cf;
        int               id;
    } rsp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   handoffs = 0;
    rsp_t exp_q[$];
    int   id_log[$];
    int   gap_q[$];
    int   m_ptr = 0;
    int   m_done = 0;
    bit   inflight = 0;
    int   grant_cyc = -100;
    bit   held = 0;
    logic [WIDTH-1:0] h_r;
    logic             h_cf;
    logic [IDW-1:0]   h_id;
    logic [NREQ-1:0]  granted = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic rsp_t model(input int id, input int a, input int b, input int op);
        rsp_t m;
        int   lim = 1 << WIDTH;
        m.id = id;
        case (op)
            0:       begin m.r = WIDTH'((a + b) % lim);       m.cf = ((a + b) >= lim); end
            1:       begin m.r = WIDTH'((a - b + lim) % lim); m.cf = (a < b);          end
            2:       begin m.r = WIDTH'(a & b);               m.cf = 1'b0;             end
            default: begin m.r = WIDTH'(a ^ b);               m.cf = 1'b0;             end
        endcase
        return m;
    endfunction

    // Monitor: predicts grants from the round-robin rule and checks every response.
    always @(negedge clk) begin : mon
        int              w;
        logic [NREQ-1:0] exp_ready;
        rsp_t            e;
        if (!rst_n) begin
            exp_q.delete();
            m_ptr    = 0;
            m_done   = 0;
            inflight = 0;
            held     = 0;
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            exp_ready = (inflight || w < 0) ? '0 : NREQ'(1) << w;
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, inflight);
            chk("done_cnt", done_cnt, m_done);
            if (rsp_valid) begin
                if (!inflight) chk("unexpected_rsp", rsp_valid, 0);
                if (held) begin
                    chk("hold_r", rsp_r, h_r);
                    chk("hold_cf", rsp_cf, h_cf);
                    chk("hold_id", rsp_id, h_id);
                end else begin
                    chk("latency", cyc - grant_cyc, 2);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_queue_empty", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_r", rsp_r, e.r);
                        chk("rsp_cf", rsp_cf, e.cf);
                        chk("rsp_id", rsp_id, e.id);
                    end
                    id_log.push_back(int'(rsp_id));
                    m_done = (m_done + 1) % (1 << CNT_W);
                    inflight = 0;
                    handoffs++;
                end
            end
            held = rsp_valid && !rsp_ready;
            h_r  = rsp_r;
            h_cf = rsp_cf;
            h_id = rsp_id;
            if (!inflight && w >= 0 && req_ready[w]) begin
                exp_q.push_back(model(w, int'(WIDTH'(req_a >> (w * WIDTH))),
                                      int'(WIDTH'(req_b >> (w * WIDTH))),
                                      int'(2'(req_op >> (w * 2)))));
                m_ptr = (w + 1) % NREQ;
                inflight = 1;
                gap_q.push_back(cyc - grant_cyc);
                grant_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        granted = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b, input int op);
        req_valid[i] = 1'b1;
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        req_op[i*2 +: 2] = 2'(op);
    endtask

    task automatic one_op(input int i, input int a, input int b, input int op, output int n);
        set_req(i, a, b, op);
        n = 0;
        do begin
            tick();
            n++;
        end while (!granted[i] && n < 20);
        if (!granted[i]) chk("grant_timeout", 0, 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_handoffs(input int target);
        int n = 0;
        while (handoffs < target && n < 60) begin
            tick();
            n++;
        end
        chk("handoff_timeout", handoffs >= target, 1);
    endtask

    initial begin : main
        int n;
        int t;
        int ref_ids[4] = '{0, 1, 0, 1};
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_cnt", done_cnt, 0);

        // Single op from requester 0
        req_valid = '0;
        rst_n = 1'b1;
        one_op(0, 4'b0100, 4'b0011, 0, n);
        chk("t2_grant_same_cycle", n, 1);
        wait_handoffs(handoffs + 1);
        chk("t2_done_cnt", done_cnt, 1);

        // Contention from reset: strict alternation
        rst_n = 1'b0;
        set_req(0, 4'b0101, 4'b0110, 0);
        set_req(1, 4'b1000, 4'b0010, 1);
        tick();
        tick();
        rst_n = 1'b1;
        id_log.delete();
        wait_handoffs(handoffs + 4);
        req_valid = '0;
        chk("t3_count", id_log.size(), 4);
        for (int k = 0; k < 4 && k < id_log.size(); k++) chk("t3_id_order", id_log[k], ref_ids[k]);

        // Backpressure for 5 cycles in RESP
        rsp_ready = 1'b0;
        one_op(0, 4'b1111, 4'b1111, 0, n);
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        repeat (5) tick();
        chk("t4_still_valid", rsp_valid, 1);
        chk("t4_done_hold", done_cnt, 4);
        rsp_ready = 1'b1;
        wait_handoffs(handoffs + 1);
        chk("t4_done_after", done_cnt, 5);

        // Reset while in EXEC discards the op and the round-robin pointer
        one_op(0, 4'b0011, 4'b0001, 1, n);
        rst_n = 1'b0;
        tick();
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done_cnt", done_cnt, 0);
        rst_n = 1'b1;
        set_req(0, 4'b0010, 4'b0111, 2);
        set_req(1, 4'b1010, 4'b0110, 3);
        @(negedge clk);
        chk("t5_rr_ptr", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_handoffs(handoffs + 1);

        // Sixteen back-to-back ops wrap the 4-bit counter
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        gap_q.delete();
        set_req(0, $urandom_range(15), $urandom_range(15), $urandom_range(3));
        t = handoffs + 16;
        n = 0;
        while (handoffs < t && n < 100) begin
            tick();
            n++;
            if (granted[0]) set_req(0, $urandom_range(15), $urandom_range(15), $urandom_range(3));
        end
        req_valid = '0;
        chk("t6_done_wrap", done_cnt, 0);
        chk("t6_grants", gap_q.size(), 16);
        for (int k = 1; k < gap_q.size(); k++) chk("t6_op_cycles", gap_q[k], 3);

        // Randomized traffic with drops and backpressure
        for (int c = 0; c < 400; c++) begin
            tick();
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (granted[i] || (req_valid[i] && $urandom_range(15) == 0)) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(2) == 0)
                    set_req(i, $urandom_range(15), $urandom_range(15), $urandom_range(3));
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (inflight && n < 20) begin
            tick();
            n++;
        end
        tick();
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
